// File: rtl/mips_alu_mdu.sv
// ============================================================================
// Module      : mips_alu_mdu
// Description : Execute-stage ALU with an iterative radix-2 multiply/divide
//               unit and HI/LO registers. Macro ALU_DIV_EN adds the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  c_LAST    = CW'(WIDTH - 1);
  localparam logic [3:0]     c_OP_XOR  = 4'd1;
  localparam logic [3:0]     c_OP_OR   = 4'd2;
  localparam logic [3:0]     c_OP_AND  = 4'd3;
  localparam logic [3:0]     c_OP_NOR  = 4'd4;
  localparam logic [3:0]     c_OP_SLL  = 4'd5;
  localparam logic [3:0]     c_OP_SRL  = 4'd6;
  localparam logic [3:0]     c_OP_SLT  = 4'd7;
  localparam logic [3:0]     c_OP_ADDU = 4'd8;
  localparam logic [3:0]     c_OP_ADD  = 4'd9;
  localparam logic [3:0]     c_OP_SUB  = 4'd10;
  localparam logic [3:0]     c_OP_SUBU = 4'd11;
  localparam logic [3:0]     c_OP_MULT = 4'd12;
`ifdef ALU_DIV_EN
  localparam logic [3:0]     c_OP_DIV  = 4'd13;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_ovf;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_mq;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_neg;
`ifdef ALU_DIV_EN
  logic                 r_is_div;
  logic                 r_sa;
  logic                 r_bz;
`endif

  logic                 w_accept;
  logic                 w_start;
  logic [WIDTH-1:0]     w_res;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_add;
  logic [WIDTH-1:0]     w_sub;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_s;
`ifdef ALU_DIV_EN
  logic                 w_is_div;
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_diff;
`endif

  assign w_accept = valid_in && !r_busy;
`ifdef ALU_DIV_EN
  assign w_is_div = (alu_operation == c_OP_DIV);
  assign w_start  = (alu_operation == c_OP_MULT) || w_is_div;
`else
  assign w_start  = (alu_operation == c_OP_MULT);
`endif

  assign w_add   = a + b;
  assign w_sub   = a - b;
  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;

  // Shift-add step: {r_acc, r_mq} shifts right, multiplier bits leave r_mq[0].
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_dvs} : '0);
  assign w_prod    = {r_acc, r_mq};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;

`ifdef ALU_DIV_EN
  // Restoring step: remainder in r_acc, dividend bits shift out of r_mq as quotient bits shift in.
  assign w_div_shift = {r_acc, r_mq[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_dvs});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_dvs;
`endif

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (alu_operation)
      c_OP_XOR:  w_res = a ^ b;
      c_OP_OR:   w_res = a | b;
      c_OP_AND:  w_res = a & b;
      c_OP_NOR:  w_res = ~(a | b);
      c_OP_SLL:  w_res = b << a[4:0];
      c_OP_SRL:  w_res = b >> a[4:0];
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_OP_ADDU: w_res = w_add;
      c_OP_ADD: begin
        w_res = w_add;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_sub;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_SUBU: w_res = w_sub;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_dvs    <= '0;
      r_neg    <= 1'b0;
`ifdef ALU_DIV_EN
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_bz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mq     <= w_abs_a;
              r_dvs    <= w_abs_b;
              r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_DIV_EN
              r_is_div <= w_is_div;
              r_sa     <= a[WIDTH-1];
              r_bz     <= (b == '0);
`endif
            end else begin
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_ovf    <= w_ovf;
              r_done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
`ifdef ALU_DIV_EN
          if (r_is_div) begin
            r_acc <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            r_mq  <= {r_mq[WIDTH-2:0], w_div_ge};
          end else
`endif
          begin
            r_acc <= w_mul_sum[WIDTH:1];
            r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
`ifdef ALU_DIV_EN
          // Divide by zero: quotient forced to all ones, remainder already equals |a|.
          if (r_is_div) begin
            r_lo <= r_bz ? '1 : (r_neg ? -r_mq : r_mq);
            r_hi <= r_sa ? -r_acc : r_acc;
          end else
`endif
          begin
            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_s[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_mdu.sv
// ============================================================================
// Module      : tb_mips_alu_mdu
// Description : Randomized self-checking bench for mips_alu_mdu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_alu_mdu;

  localparam int W = 32;
  localparam longint c_MAXS = 64'sd2147483647;
  localparam longint c_MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [3:0]   alu_operation = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  mips_alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_operation(alu_operation),
    .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void ref_single(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r, output logic ov);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    ov = 1'b0;
    case (op)
      4'd1:  r = x ^ y;
      4'd2:  r = x | y;
      4'd3:  r = x & y;
      4'd4:  r = ~(x | y);
      4'd5:  r = y << x[4:0];
      4'd6:  r = y >> x[4:0];
      4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  r = x + y;
      4'd9:  begin s = sx + sy; r = s[31:0]; ov = (s > c_MAXS) || (s < c_MINS); end
      4'd10: begin s = sx - sy; r = s[31:0]; ov = (s > c_MAXS) || (s < c_MINS); end
      4'd11: r = x - y;
      default: r = '0;
    endcase
  endfunction

  function automatic void ref_mdu(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, p, q, rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!is_div) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == 0) begin
      h = x;
      l = '1;
    end else begin
      q  = sx / sy;
      rm = sx % sy;
      h  = rm[31:0];
      l  = q[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge, then scramble operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    valid_in = 1'b1;
    alu_operation = op;
    a = x;
    b = y;
    tick();
    valid_in = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run_mdu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int edges, output int busy_cycles);
    issue(op, x, y);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 200) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({result, zero, overflow, hi, lo, busy, done} !== {32'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in got r=%h z=%b o=%b hi=%h lo=%h busy=%b done=%b exp 0/1/0/0/0/0/0",
               result, zero, overflow, hi, lo, busy, done);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({result, zero, overflow, hi, lo, busy, done} !== {32'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle got r=%h z=%b o=%b hi=%h lo=%h busy=%b done=%b exp 0/1/0/0/0/0/0",
               result, zero, overflow, hi, lo, busy, done);
    end
  endtask

  task automatic test_single();
    logic [3:0]  d_op [8] = '{4'd9, 4'd8, 4'd5, 4'd6, 4'd7, 4'd10, 4'd10, 4'd11};
    logic [31:0] d_a  [8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd4, 32'd31, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [31:0] d_b  [8] = '{32'd1, 32'd1, 32'd1, 32'h80000000, 32'd0, 32'd5, 32'd1, 32'd1};
    logic [3:0]  op;
    logic [31:0] x, y, er;
    logic        eo;
    for (int i = 0; i < 68; i++) begin
      if (i < 8) begin
        op = d_op[i]; x = d_a[i]; y = d_b[i];
      end else begin
        op = 4'($urandom_range(1, 11));
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? x : $urandom;
        if ($urandom_range(0, 3) == 0) x = {x[31], {31{~x[31]}}};
      end
      ref_single(op, x, y, er, eo);
      issue(op, x, y);
      checks++;
      if ({result, zero, overflow, done} !== {er, (er == 32'd0), eo, 1'b1}) begin
        errors++;
        $display("FAIL single op=%0d a=%h b=%h got r=%h z=%b o=%b d=%b exp r=%h z=%b o=%b d=1",
                 op, x, y, result, zero, overflow, done, er, (er == 32'd0), eo);
      end
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL single_pulse op=%0d got done=%b busy=%b exp 0/0", op, done, busy);
      end
    end
  endtask

  task automatic check_mdu(input bit is_div, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el, r0;
    logic        z0, o0;
    int          edges, bc;
    r0 = result; z0 = zero; o0 = overflow;
    ref_mdu(is_div, x, y, eh, el);
    run_mdu(is_div ? 4'd13 : 4'd12, x, y, edges, bc);
    checks++;
    if (edges != W + 1 || bc != W + 1) begin
      errors++;
      $display("FAIL mdu_latency div=%0d got edges=%0d busy=%0d exp %0d/%0d", is_div, edges, bc, W + 1, W + 1);
    end
    checks++;
    if ({hi, lo} !== {eh, el}) begin
      errors++;
      $display("FAIL mdu_value div=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", is_div, x, y, hi, lo, eh, el);
    end
    checks++;
    if ({result, zero, overflow} !== {r0, z0, o0}) begin
      errors++;
      $display("FAIL mdu_result_kept got r=%h z=%b o=%b exp r=%h z=%b o=%b", result, zero, overflow, r0, z0, o0);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mdu_pulse got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_mult();
    logic [31:0] d_a [4] = '{32'hFFFFFFFD, 32'd7, 32'h80000000, 32'h80000000};
    logic [31:0] d_b [4] = '{32'd5, 32'd9, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) check_mdu(1'b0, d_a[i], d_b[i]);
    for (int i = 0; i < 5; i++) check_mdu(1'b0, $urandom, $urandom);
  endtask

  task automatic test_div();
`ifdef ALU_DIV_EN
    logic [31:0] d_a [6] = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'd7, 32'hFFFFFFF7, 32'd3};
    logic [31:0] d_b [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd10};
    for (int i = 0; i < 6; i++) check_mdu(1'b1, d_a[i], d_b[i]);
    for (int i = 0; i < 6; i++)
      check_mdu(1'b1, $urandom, (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
`else
    logic [31:0] h0, l0;
    issue(4'd9, 32'h7FFFFFFF, 32'd1);
    h0 = hi; l0 = lo;
    issue(4'd13, 32'hFFFFFFF9, 32'd2);
    checks++;
    if ({result, zero, overflow, done, busy, hi, lo} !== {32'd0, 1'b1, 1'b0, 1'b1, 1'b0, h0, l0}) begin
      errors++;
      $display("FAIL div_disabled got r=%h z=%b o=%b d=%b busy=%b hi=%h lo=%h exp 0/1/0/1/0 hi=%h lo=%h",
               result, zero, overflow, done, busy, hi, lo, h0, l0);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL div_disabled_pulse got done=%b busy=%b exp 0/0", done, busy);
    end
`endif
  endtask

  task automatic test_illegal();
`ifdef ALU_DIV_EN
    logic [3:0] ops [3] = '{4'd0, 4'd14, 4'd15};
`else
    logic [3:0] ops [4] = '{4'd0, 4'd14, 4'd15, 4'd13};
`endif
    logic [31:0] h0, l0;
    foreach (ops[i]) begin
      issue(4'd9, 32'h7FFFFFFF, 32'd1);
      h0 = hi; l0 = lo;
      issue(ops[i], $urandom, $urandom);
      checks++;
      if ({result, zero, overflow, done, busy, hi, lo} !== {32'd0, 1'b1, 1'b0, 1'b1, 1'b0, h0, l0}) begin
        errors++;
        $display("FAIL illegal op=%0d got r=%h z=%b o=%b d=%b busy=%b hi=%h lo=%h exp 0/1/0/1/0 hi=%h lo=%h",
                 ops[i], result, zero, overflow, done, busy, hi, lo, h0, l0);
      end
    end
  endtask

  task automatic test_busy();
    logic [31:0] r0;
    int          edges;
    issue(4'd1, 32'h00001234, 32'h0000FF00);
    r0 = result;
    issue(4'd12, 32'd11, 32'd13);
    repeat (4) tick();
    valid_in = 1'b1; alu_operation = 4'd1; a = 32'hFFFFFFFF; b = 32'd0;
    tick();
    valid_in = 1'b0;
    edges = 5;
    while (!done && edges < 200) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != W + 1 || result !== r0 || {hi, lo} !== {32'd0, 32'd143}) begin
      errors++;
      $display("FAIL busy_ignore got edges=%0d r=%h hi=%h lo=%h exp %0d r=%h hi=0 lo=8f",
               edges, result, hi, lo, W + 1, r0);
    end
    tick();
    issue(4'd1, 32'hFFFFFFFF, 32'd0);
    checks++;
    if ({result, done} !== {32'hFFFFFFFF, 1'b1}) begin
      errors++;
      $display("FAIL busy_reissue got r=%h d=%b exp ffffffff/1", result, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, er, eh, el;
    logic        eo;
    int          edges, bc;
    x = $urandom; y = $urandom;
    ref_single(4'd8, x, y, er, eo);
    ref_mdu(1'b0, 32'd1234, 32'd5678, eh, el);
    run_mdu(4'd12, 32'd1234, 32'd5678, edges, bc);
    issue(4'd8, x, y);
    checks++;
    if ({result, zero, overflow, done, hi, lo} !== {er, (er == 32'd0), eo, 1'b1, eh, el}) begin
      errors++;
      $display("FAIL b2b_after_done got r=%h d=%b hi=%h lo=%h exp r=%h d=1 hi=%h lo=%h",
               result, done, hi, lo, er, eh, el);
    end
    run_mdu(4'd12, 32'hFFFFFF00, 32'd3, edges, bc);
    checks++;
    if (edges != W + 1 || {hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFD00}) begin
      errors++;
      $display("FAIL b2b_mult_after_single got edges=%0d hi=%h lo=%h exp %0d ffffffff/fffffd00",
               edges, hi, lo, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    issue(4'd12, 32'd7, 32'd9);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo, result, zero} !== {1'b0, 1'b0, 64'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got busy=%b d=%b hi=%h lo=%h r=%h z=%b exp 0/0/0/0/0/1",
               busy, done, hi, lo, result, zero);
    end
    #2;
    rst_n = 1'b1;
    tick();
    issue(4'd9, 32'd2, 32'd3);
    checks++;
    if ({result, zero, overflow, done} !== {32'd5, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_add got r=%h z=%b o=%b d=%b exp 5/0/0/1", result, zero, overflow, done);
    end
    repeat (40) tick();
    checks++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_mid_discard got busy=%b d=%b hi=%h lo=%h exp 0/0/0/0", busy, done, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mult();
    test_div();
    test_illegal();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
